// File: rtl/led_pattern_if.sv
// led_pattern_if: board-facing signal bundle of the LED pattern controller.
//
// Signals:
//   key_mode, key_speed, key_pause : raw active-low push keys (asynchronous to sys_clk)
//   led[3:0]                       : LED drive, 1 = on
//   mode[1:0], speed[1:0], paused  : current controller state (registered)
//   step_pulse                     : one-cycle strobe on each pattern step
//
// Handshake: there is no valid/ready pair here. Keys are free-running levels
// that the controller synchronises and debounces itself. The status outputs are
// plain levels that change only on sys_clk edges, except during reset.
//
// Modports:
//   master : bench/board side, drives the keys and observes the outputs
//   slave  : controller side
interface led_pattern_if;
  logic       key_mode;
  logic       key_speed;
  logic       key_pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       paused;
  logic       step_pulse;

  modport master (
    output key_mode, key_speed, key_pause,
    input  led, mode, speed, paused, step_pulse
  );

  modport slave (
    input  key_mode, key_speed, key_pause,
    output led, mode, speed, paused, step_pulse
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 4-LED pattern sequencer with three debounced keys.
//
// Ports:
//   sys_clk    : system clock
//   sys_rst_n  : asynchronous reset, active-low
//   bus        : led_pattern_if.slave (keys in; led/mode/speed/paused/step_pulse out)
//
// Keys: mode cycles FLOW_L, FLOW_R, BOUNCE, BLINK. Speed cycles the step period
// through BASE_PERIOD >> 0..3. Pause freezes the step counter.
// Each key passes through a 2-FF synchroniser and a DEB_CNT-clock debouncer;
// only the press (1->0) of the debounced level makes a one-cycle event.
//
// Optional build macro LED_PWM_EN: when defined, the LED outputs are gated by
// a free-running PWM counter (0..PWM_PERIOD, on while below PWM_DUTY). The
// pattern register itself is never gated.
module led_pattern_ctrl #(
  parameter logic [23:0] BASE_PERIOD = 24'd1_000_000,
  parameter logic [19:0] DEB_CNT     = 20'd1_000_000,
  parameter logic [7:0]  PWM_PERIOD  = 8'd255,
  parameter logic [7:0]  PWM_DUTY    = 8'd64
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  led_pattern_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_FLOW_L = 2'd0,
    MODE_FLOW_R = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  // ---------------------------------------------------------------- key path
  // Bit order everywhere: [0] mode, [1] speed, [2] pause.
  logic [2:0]  key_raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  deb;
  logic [2:0]  press;
  logic [19:0] deb_cnt [3];

  assign key_raw = {bus.key_pause, bus.key_speed, bus.key_mode};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      deb   <= 3'b111;
      press <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_CNT - 20'd1) begin
          // Difference held for DEB_CNT clocks: accept it. Only a press
          // (new level 0) produces an event, registered so it lasts one cycle.
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
          press[i]   <= ~sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  logic mode_evt;
  logic speed_evt;
  logic pause_evt;

  assign mode_evt  = press[0];
  assign speed_evt = press[1];
  assign pause_evt = press[2];

  // ------------------------------------------------------- step / pattern FSM
  mode_t       mode_q;
  logic [1:0]  next_mode;
  logic [1:0]  speed_q;
  logic        paused_q;
  logic [3:0]  pattern;
  logic        dir_right;
  logic [23:0] cnt;
  logic [23:0] period;
  logic        step;

  assign next_mode = mode_q + 2'd1;
  assign period    = BASE_PERIOD >> speed_q;
  assign step      = ~paused_q && (cnt == period - 24'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q    <= MODE_FLOW_L;
      speed_q   <= 2'd0;
      paused_q  <= 1'b0;
      pattern   <= 4'b0001;
      dir_right <= 1'b0;
      cnt       <= '0;
    end else begin
      if (pause_evt) paused_q <= ~paused_q;
      if (speed_evt) speed_q  <= speed_q + 2'd1;

      // Mode and speed presses restart the period; they also swallow a
      // coincident step so the new setting starts from a clean count.
      if (mode_evt || speed_evt) begin
        cnt <= '0;
      end else if (!paused_q) begin
        cnt <= step ? 24'd0 : cnt + 24'd1;
      end

      if (mode_evt) begin
        mode_q    <= mode_t'(next_mode);
        dir_right <= 1'b0;
        case (next_mode)
          2'd0:    pattern <= 4'b0001;
          2'd1:    pattern <= 4'b1000;
          2'd2:    pattern <= 4'b0001;
          default: pattern <= 4'b1111;
        endcase
      end else if (!speed_evt && step) begin
        case (mode_q)
          MODE_FLOW_L: pattern <= {pattern[2:0], pattern[3]};
          MODE_FLOW_R: pattern <= {pattern[0], pattern[3:1]};
          MODE_BOUNCE: begin
            // Flip direction as the lit LED lands on an end, so the end LED
            // is shown once and the next step heads back.
            if (!dir_right) begin
              pattern <= {pattern[2:0], 1'b0};
              if (pattern == 4'b0100) dir_right <= 1'b1;
            end else begin
              pattern <= {1'b0, pattern[3:1]};
              if (pattern == 4'b0010) dir_right <= 1'b0;
            end
          end
          default:     pattern <= ~pattern;
        endcase
      end
    end
  end

  assign bus.mode       = mode_q;
  assign bus.speed      = speed_q;
  assign bus.paused     = paused_q;
  assign bus.step_pulse = step;

  // ------------------------------------------------------------ LED output
`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_PERIOD) ? 8'd0 : pwm_cnt + 8'd1;
    end
  end

  assign bus.led = pattern & {4{pwm_cnt < PWM_DUTY}};
`else
  // PWM parameters have no effect in this build.
  logic unused_pwm;
  assign unused_pwm = ^{PWM_PERIOD, PWM_DUTY};

  assign bus.led = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed bench for led_pattern_ctrl (BASE_PERIOD=16,
// DEB_CNT=4). A behavioural model, kept in terms of "position within the
// current pattern sequence", predicts the outputs after every clock edge and
// pushes them onto exp_q; a compare process pops and checks every cycle.
// Directed steps add hand-computed literal expectations.
module tb_led_pattern_ctrl;

  localparam int BP = 16;
  localparam int DC = 4;

  // ------------------------------------------------------ clock / reset
  logic sys_clk;
  logic sys_rst_n;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  led_pattern_if bus ();

  led_pattern_ctrl #(
    .BASE_PERIOD (24'd16),
    .DEB_CNT     (20'd4),
    .PWM_PERIOD  (8'd3),
    .PWM_DUTY    (8'd1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // ------------------------------------------------------ bookkeeping
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------ model
  // Output vector: {led[3:0], mode[1:0], speed[1:0], paused, step_pulse}
  logic [9:0] exp_q [$];

  int         m_mode;
  int         m_speed;
  int         m_pos;     // index within the current mode's repeating sequence
  int         m_cnt;     // clocks elapsed in the current step period
  bit         m_paused;
  bit   [2:0] m_deb;
  bit   [2:0] m_evt;     // events accepted this edge, acted on next edge
  logic [2:0] key_hist [$];  // synchronised-key samples, newest first
  int         m_pwm;
  bit   [2:0] cur_evt;
  bit         m_step;
  bit         h_same;
  bit         h_v;

  function automatic int seq_len(input int md);
    if (md == 2) return 6;
    if (md == 3) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] pattern_of(input int md, input int pos);
    case (md)
      0: return 4'b0001 << pos;
      1: return 4'b1000 >> pos;
      2: case (pos)
           0: return 4'b0001;
           1: return 4'b0010;
           2: return 4'b0100;
           3: return 4'b1000;
           4: return 4'b0100;
           default: return 4'b0010;
         endcase
      default: return (pos == 0) ? 4'b1111 : 4'b0000;
    endcase
  endfunction

  function automatic logic [9:0] model_out();
    logic [3:0] l;
    int per;
    per = BP >> m_speed;
    l = pattern_of(m_mode, m_pos);
`ifdef LED_PWM_EN
    if (!(m_pwm < 1)) l = 4'b0000;
`endif
    return {l, 2'(m_mode), 2'(m_speed), m_paused, (!m_paused && m_cnt == per - 1)};
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_mode = 0; m_speed = 0; m_pos = 0; m_cnt = 0; m_paused = 0;
      m_deb = 3'b111; m_evt = 3'b000; m_pwm = 0;
      key_hist.delete();
      for (int j = 0; j < DC + 2; j++) key_hist.push_back(3'b111);
      exp_q.delete();
      exp_q.push_back(model_out());
    end else begin
      cur_evt = m_evt;
      m_step  = !m_paused && (m_cnt == (BP >> m_speed) - 1);
      if (cur_evt[0] || cur_evt[1]) begin
        if (cur_evt[0]) begin
          m_mode = (m_mode + 1) % 4;
          m_pos  = 0;
        end
        if (cur_evt[1]) m_speed = (m_speed + 1) % 4;
        m_cnt = 0;
      end else if (!m_paused) begin
        if (m_step) begin
          m_pos = (m_pos + 1) % seq_len(m_mode);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (cur_evt[2]) m_paused = !m_paused;
      m_pwm = (m_pwm + 1) % 4;

      // A key is accepted once the last DC synchronised samples (2 clocks of
      // synchroniser delay) all agree on a level different from the current one.
      key_hist.push_front({bus.key_pause, bus.key_speed, bus.key_mode});
      key_hist.pop_back();
      m_evt = 3'b000;
      for (int k = 0; k < 3; k++) begin
        h_v    = key_hist[2][k];
        h_same = 1'b1;
        for (int j = 3; j < DC + 2; j++) if (key_hist[j][k] != h_v) h_same = 1'b0;
        if (h_same && h_v != m_deb[k]) begin
          m_deb[k] = h_v;
          m_evt[k] = !h_v;
        end
      end
      exp_q.push_back(model_out());
    end
  end

  // ------------------------------------------------------ scoreboard
  logic [9:0] exp_v;
  always @(negedge sys_clk) begin
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      exp_v = exp_q.pop_front();
      check("cycle {led,mode,speed,paused,step}",
            {22'd0, bus.led, bus.mode, bus.speed, bus.paused, bus.step_pulse},
            {22'd0, exp_v});
    end
  end

  // ------------------------------------------------------ drivers
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: bus.key_mode  = v;
      1: bus.key_speed = v;
      default: bus.key_pause = v;
    endcase
  endtask

  // Returns at the negedge just after the event has been applied (key still low).
  task automatic press_event(input int k);
    set_key(k, 1'b0);
    tick(7);
  endtask

  // Keeps the key low 10 clocks in total, releases, waits for the release to settle.
  task automatic release_key(input int k);
    tick(3);
    set_key(k, 1'b1);
    tick(6);
  endtask

  // ------------------------------------------------------ directed sequence
  logic [3:0] flow_seq [4];
  logic [3:0] bnc_seq [6];

  initial begin
    flow_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bnc_seq  = '{4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    sys_rst_n     = 1'b0;
    bus.key_mode  = 1'b1;
    bus.key_speed = 1'b1;
    bus.key_pause = 1'b1;
    tick(2);
    check("rst_led", 32'(bus.led), 32'b0001);
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_step", 32'(bus.step_pulse), 32'd0);
    sys_rst_n = 1'b1;

    // Free-running FLOW_L, a step every 16 clocks, strobe one cycle wide.
    tick(15);
    check("t1_first_pulse", 32'(bus.step_pulse), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t1_led", 32'(bus.led), 32'(flow_seq[i]));
      check("t1_pulse_low", 32'(bus.step_pulse), 32'd0);
      tick(15);
      check("t1_pulse", 32'(bus.step_pulse), 32'd1);
    end

    // Two-clock glitch ignored; a real press lands 2 + DEB_CNT clocks later.
    set_key(0, 1'b0);
    tick(2);
    set_key(0, 1'b1);
    tick(8);
    check("t2_glitch_mode", 32'(bus.mode), 32'd0);
    set_key(0, 1'b0);
    tick(6);
    check("t2_not_yet", 32'(bus.mode), 32'd0);
    tick(1);
    check("t2_mode", 32'(bus.mode), 32'd1);
    check("t2_led_init", 32'(bus.led), 32'b1000);
    tick(3);
    set_key(0, 1'b1);
    tick(13);
    check("t2_rot_right", 32'(bus.led), 32'b0100);
    tick(6);
    check("t2_one_event", 32'(bus.mode), 32'd1);

    // BOUNCE sequence.
    press_event(0);
    check("t3_mode", 32'(bus.mode), 32'd2);
    check("t3_led_init", 32'(bus.led), 32'b0001);
    release_key(0);
    tick(7);
    check("t3_led1", 32'(bus.led), 32'b0010);
    for (int i = 0; i < 6; i++) begin
      tick(16);
      check("t3_bounce", 32'(bus.led), 32'(bnc_seq[i]));
    end

    // Speed: three presses to P=2, a fourth wraps back to P=16.
    for (int i = 0; i < 3; i++) begin
      press_event(1);
      check("t4_speed", 32'(bus.speed), 32'(i + 1));
      release_key(1);
    end
    check("t4_p2_a", 32'(bus.step_pulse), 32'd1);
    tick(1);
    check("t4_p2_b", 32'(bus.step_pulse), 32'd0);
    tick(1);
    check("t4_p2_c", 32'(bus.step_pulse), 32'd1);
    press_event(1);
    check("t4_wrap", 32'(bus.speed), 32'd0);
    check("t4_cnt0", 32'(bus.step_pulse), 32'd0);
    release_key(1);
    tick(6);
    check("t4_p16", 32'(bus.step_pulse), 32'd1);

    // Pause lands on cnt=7, freezes at 8; resume gives a step 8 clocks on.
    tick(2);
    press_event(2);
    check("t5_paused", 32'(bus.paused), 32'd1);
    release_key(2);
    tick(100);
    check("t5_still_paused", 32'(bus.paused), 32'd1);
    check("t5_no_step", 32'(bus.step_pulse), 32'd0);
    press_event(2);
    check("t5_resumed", 32'(bus.paused), 32'd0);
    tick(6);
    check("t5_pre_step", 32'(bus.step_pulse), 32'd0);
    tick(1);
    check("t5_step", 32'(bus.step_pulse), 32'd1);
    release_key(2);

    // BLINK, then mode+pause pressed together.
    press_event(0);
    check("t6_blink_mode", 32'(bus.mode), 32'd3);
    check("t6_blink_on", 32'(bus.led), 32'b1111);
    release_key(0);
    tick(7);
    check("t6_blink_off", 32'(bus.led), 32'b0000);
    bus.key_mode  = 1'b0;
    bus.key_pause = 1'b0;
    tick(7);
    check("t6_both_mode", 32'(bus.mode), 32'd0);
    check("t6_both_paused", 32'(bus.paused), 32'd1);
    check("t6_both_led", 32'(bus.led), 32'b0001);
    tick(3);
    bus.key_mode  = 1'b1;
    bus.key_pause = 1'b1;
    tick(6);
    press_event(1);
    check("t6_speed1", 32'(bus.speed), 32'd1);
    release_key(1);

    // Asynchronous reset between clock edges.
    #3 sys_rst_n = 1'b0;
    #1;
    check("arst_led", 32'(bus.led), 32'b0001);
    check("arst_mode", 32'(bus.mode), 32'd0);
    check("arst_speed", 32'(bus.speed), 32'd0);
    check("arst_paused", 32'(bus.paused), 32'd0);
    check("arst_step", 32'(bus.step_pulse), 32'd0);
    tick(2);
    sys_rst_n = 1'b1;
    tick(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
